// File: rtl/split_arbiter.sv
// Bus arbiter for two initiators plus a split-capable target that can reclaim
// the bus to return deferred read data. Grants are decoded from registered state.
module split_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic init1_req,
    input  logic init2_req,
    input  logic txn_ack,
    input  logic txn_split_ack,
    input  logic split_req,
    output logic init1_grant,
    output logic init2_grant,
    output logic split_grant,
    output logic split_pending,
    output logic split_owner,
    output logic busy,
    output logic protocol_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT1,
        GRANT2,
        SPLIT_GRANT
    } state_t;

    localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT - 1);

    state_t     r_state;
    state_t     w_nextState;
    logic [9:0] r_watchdog;
    logic       r_lastGrant;
    logic       r_splitPending;
    logic       r_splitOwner;
    logic       r_protocolErr;
    logic       w_setPending;
    logic       w_clrPending;
    logic       w_setErr;
    logic       w_elig1;
    logic       w_elig2;
    logic       w_ownReq;
    logic       w_timeout;

    // An initiator owed deferred data may not start a new transaction meanwhile.
    assign w_elig1   = init1_req && !(r_splitPending && !r_splitOwner);
    assign w_elig2   = init2_req && !(r_splitPending && r_splitOwner);
    assign w_ownReq  = (r_state == GRANT1) ? init1_req : init2_req;
    assign w_timeout = (r_watchdog == WD_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_setPending = 1'b0;
        w_clrPending = 1'b0;
        w_setErr     = 1'b0;
        case (r_state)
            IDLE: begin
                if (txn_ack || txn_split_ack) w_setErr = 1'b1;
                if (split_req && !r_splitPending) w_setErr = 1'b1;
                if (split_req && r_splitPending) begin
                    w_nextState = SPLIT_GRANT;
                end else if (w_elig1 && w_elig2) begin
                    w_nextState = r_lastGrant ? GRANT1 : GRANT2;
                end else if (w_elig1) begin
                    w_nextState = GRANT1;
                end else if (w_elig2) begin
                    w_nextState = GRANT2;
                end
            end
            GRANT1, GRANT2: begin
                // Split ack outranks a simultaneous ack; a second split while one
                // is outstanding is an error and simply ends the transaction.
                if (txn_split_ack) begin
                    w_nextState = IDLE;
                    if (r_splitPending) w_setErr = 1'b1;
                    else                w_setPending = 1'b1;
                end else if (txn_ack || !w_ownReq) begin
                    w_nextState = IDLE;
                end else if (w_timeout) begin
                    w_nextState = IDLE;
                    w_setErr    = 1'b1;
                end
            end
            SPLIT_GRANT: begin
                if (txn_split_ack) w_setErr = 1'b1;
                if (txn_ack) begin
                    w_nextState  = IDLE;
                    w_clrPending = 1'b1;
                end else if (!split_req) begin
                    w_nextState = IDLE;
                end else if (w_timeout) begin
                    w_nextState  = IDLE;
                    w_clrPending = 1'b1;
                    w_setErr     = 1'b1;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_watchdog     <= '0;
            r_lastGrant    <= 1'b1;
            r_splitPending <= 1'b0;
            r_splitOwner   <= 1'b0;
            r_protocolErr  <= 1'b0;
        end else begin
            r_watchdog <= (r_state == IDLE) ? 10'd0 : r_watchdog + 10'd1;
            if (r_state == IDLE && (w_nextState == GRANT1 || w_nextState == GRANT2)) begin
                r_lastGrant <= (w_nextState == GRANT2);
            end
            if (w_setPending) begin
                r_splitPending <= 1'b1;
                r_splitOwner   <= (r_state == GRANT2);
            end else if (w_clrPending) begin
                r_splitPending <= 1'b0;
            end
            if (w_setErr) r_protocolErr <= 1'b1;
        end
    end

    always_comb begin
        init1_grant   = (r_state == GRANT1);
        init2_grant   = (r_state == GRANT2);
        split_grant   = (r_state == SPLIT_GRANT);
        busy          = (r_state != IDLE);
        split_pending = r_splitPending;
        split_owner   = r_splitOwner;
        protocol_err  = r_protocolErr;
    end

endmodule

// File: tb/tb_split_arbiter.sv
// Scoreboard bench for split_arbiter: each step queues its inputs with the outputs
// expected after the next rising edge; every test task drains and compares them.
module tb_split_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic init1Req = 1'b0, init2Req = 1'b0, txnAck = 1'b0, txnSplitAck = 1'b0, splitReq = 1'b0;

    logic g1A, g2A, sgA, busyA, pendA, ownerA, errA;
    logic g1B, g2B, sgB, busyB, pendB, ownerB, errB;
    logic [6:0] obsMain, obsTimeout;

    assign obsMain    = {g1A, g2A, sgA, busyA, pendA, ownerA, errA};
    assign obsTimeout = {g1B, g2B, sgB, busyB, pendB, ownerB, errB};

    typedef struct {
        logic [4:0] stim;
        logic [6:0] exp;
        string      name;
    } step_t;

    step_t sbQ[$];
    int    total = 0;
    int    bad = 0;

    always #5 clk = ~clk;

    split_arbiter dut (
        .clk(clk), .rst(rst), .init1_req(init1Req), .init2_req(init2Req),
        .txn_ack(txnAck), .txn_split_ack(txnSplitAck), .split_req(splitReq),
        .init1_grant(g1A), .init2_grant(g2A), .split_grant(sgA),
        .split_pending(pendA), .split_owner(ownerA), .busy(busyA), .protocol_err(errA)
    );

    split_arbiter #(.TIMEOUT(4)) dutT (
        .clk(clk), .rst(rst), .init1_req(init1Req), .init2_req(init2Req),
        .txn_ack(txnAck), .txn_split_ack(txnSplitAck), .split_req(splitReq),
        .init1_grant(g1B), .init2_grant(g2B), .split_grant(sgB),
        .split_pending(pendB), .split_owner(ownerB), .busy(busyB), .protocol_err(errB)
    );

    // stim = {init1_req, init2_req, txn_ack, txn_split_ack, split_req}
    // exp  = {init1_grant, init2_grant, split_grant, busy, split_pending, split_owner, protocol_err}
    task automatic pushStep(input logic [4:0] st, input logic [6:0] ex, input string nm);
        step_t s;
        s.stim = st;
        s.exp  = ex;
        s.name = nm;
        sbQ.push_back(s);
    endtask

    task automatic doReset();
        {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = 5'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        init1Req = 1'b1;
        #1;
        total++;
        if (obsMain !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_main: got %b want %b", obsMain, 7'b0);
        end
        @(posedge clk);
        #1;
        total++;
        if (obsTimeout !== 7'b0) begin
            bad++;
            $display("[TB] FAIL reset_held: got %b want %b", obsTimeout, 7'b0);
        end
        rst = 1'b0;
        init1Req = 1'b0;
    endtask

    task automatic test_basic();
        doReset();
        pushStep(5'b10000, 7'b1001000, "basic c0");
        pushStep(5'b10000, 7'b1001000, "basic c1");
        pushStep(5'b10000, 7'b1001000, "basic c2");
        pushStep(5'b10000, 7'b1001000, "basic c3");
        pushStep(5'b10100, 7'b0000000, "basic c4");
        pushStep(5'b00000, 7'b0000000, "basic c5");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
    endtask

    task automatic test_round_robin();
        doReset();
        pushStep(5'b11000, 7'b1001000, "rr g1");
        pushStep(5'b11100, 7'b0000000, "rr idle1");
        pushStep(5'b11000, 7'b0101000, "rr g2");
        pushStep(5'b11100, 7'b0000000, "rr idle2");
        pushStep(5'b11000, 7'b1001000, "rr g1 again");
        pushStep(5'b11100, 7'b0000000, "rr idle3");
        pushStep(5'b00000, 7'b0000000, "rr quiet");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
    endtask

    task automatic test_split();
        doReset();
        pushStep(5'b10000, 7'b1001000, "split g1");
        pushStep(5'b10010, 7'b0000100, "split deferred owner1");
        pushStep(5'b11000, 7'b0101100, "split g2 skips owner");
        pushStep(5'b11100, 7'b0000100, "split g2 done");
        pushStep(5'b10001, 7'b0011100, "split target granted");
        pushStep(5'b10001, 7'b0011100, "split target held");
        pushStep(5'b10101, 7'b0000000, "split returned");
        pushStep(5'b10000, 7'b1001000, "split g1 eligible again");
        pushStep(5'b00100, 7'b0000000, "split end");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
    endtask

    task automatic test_timeout();
        doReset();
        pushStep(5'b10000, 7'b1001000, "to g1 c0");
        pushStep(5'b10000, 7'b1001000, "to g1 c1");
        pushStep(5'b10000, 7'b1001000, "to g1 c2");
        pushStep(5'b10000, 7'b1001000, "to g1 c3");
        pushStep(5'b10000, 7'b0000001, "to g1 expired");
        pushStep(5'b00000, 7'b0000001, "to err sticky");
        pushStep(5'b01000, 7'b0101001, "to g2");
        pushStep(5'b00010, 7'b0000111, "to deferred owner2");
        pushStep(5'b00001, 7'b0011111, "to split c0");
        pushStep(5'b00001, 7'b0011111, "to split c1");
        pushStep(5'b00001, 7'b0011111, "to split c2");
        pushStep(5'b00001, 7'b0011111, "to split c3");
        pushStep(5'b00001, 7'b0000011, "to split expired");
        pushStep(5'b00000, 7'b0000011, "to quiet");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsTimeout !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsTimeout, s.exp);
            end
        end
    endtask

    task automatic test_protocol_errors();
        doReset();
        pushStep(5'b01000, 7'b0101000, "pe g2");
        pushStep(5'b01110, 7'b0000110, "pe both acks split wins");
        pushStep(5'b10000, 7'b1001110, "pe g1 while owner2");
        pushStep(5'b10010, 7'b0000111, "pe second split");
        pushStep(5'b00000, 7'b0000111, "pe idle");
        pushStep(5'b00001, 7'b0011111, "pe split grant");
        pushStep(5'b00000, 7'b0000111, "pe split_req dropped");
        pushStep(5'b00000, 7'b0000111, "pe still pending");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
        doReset();
        pushStep(5'b00001, 7'b0000001, "pe stray split_req");
        pushStep(5'b00000, 7'b0000001, "pe stray split_req sticky");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
        doReset();
        pushStep(5'b00100, 7'b0000001, "pe ack in idle");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
    endtask

    task automatic test_reset_midflight();
        doReset();
        pushStep(5'b10100, 7'b1001001, "mf g1 with idle ack err");
        pushStep(5'b10010, 7'b0000101, "mf deferred");
        pushStep(5'b00001, 7'b0011101, "mf split grant");
        pushStep(5'b00001, 7'b0011101, "mf split held");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
        init1Req = 1'b1;
        init2Req = 1'b1;
        #2 rst = 1'b1;
        #1;
        total++;
        if (obsMain !== 7'b0) begin
            bad++;
            $display("[TB] FAIL mf async reset: got %b want %b", obsMain, 7'b0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        pushStep(5'b11000, 7'b1001000, "mf first tie to init1");
        while (sbQ.size() > 0) begin
            step_t s;
            s = sbQ.pop_front();
            {init1Req, init2Req, txnAck, txnSplitAck, splitReq} = s.stim;
            @(posedge clk);
            #1;
            total++;
            if (obsMain !== s.exp) begin
                bad++;
                $display("[TB] FAIL %s: got %b want %b", s.name, obsMain, s.exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_round_robin();
        test_split();
        test_timeout();
        test_protocol_errors();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/split_arbiter.md
SPLIT_ARBITER -- requirements
Module: split_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64, the maximum number of grant cycles without completion before forced release; legal range 2..1023.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port init1_req  input  1  initiator 1 bus request (level).
REQ-005 SHALL have port init2_req  input  1  initiator 2 bus request (level).
REQ-006 SHALL have port txn_ack  input  1  one-cycle pulse: addressed target completed the current transaction.
REQ-007 SHALL have port txn_split_ack  input  1  one-cycle pulse: split-capable target deferred the current read.
REQ-008 SHALL have port split_req  input  1  split target requests the bus to return deferred data (level).
REQ-009 SHALL have port init1_grant  output  1  initiator 1 owns the bus.
REQ-010 SHALL have port init2_grant  output  1  initiator 2 owns the bus.
REQ-011 SHALL have port split_grant  output  1  split target owns the bus.
REQ-012 SHALL have port split_pending  output  1  a deferred transaction is outstanding.
REQ-013 SHALL have port split_owner  output  1  initiator owed the deferred data (0 = init1, 1 = init2); valid while split_pending.
REQ-014 SHALL have port busy  output  1  high in any grant state.
REQ-015 SHALL have port protocol_err  output  1  sticky error flag; cleared only by rst.

Function
REQ-016 SHALL implement states IDLE, GRANT1, GRANT2, SPLIT_GRANT; grant outputs are registered, decoded from state, and at most one is high per cycle.
REQ-017 SHALL, in IDLE, select by priority: split_req with split_pending -> SPLIT_GRANT; otherwise eligible initiator requests -> GRANT1/GRANT2; otherwise stay IDLE.
REQ-018 SHALL treat an initiator as ineligible while split_pending and split_owner names it.
REQ-019 SHALL break ties between two eligible requests round-robin via a last_grant register; last_grant resets to init2 so init1 wins the first tie.
REQ-020 SHALL assert grant in the cycle after the request is sampled in IDLE (one-cycle grant latency).
REQ-021 SHALL hold GRANTx until txn_ack, txn_split_ack, initX_req deassertion, or timeout, then return to IDLE; grant low the next cycle.
REQ-022 SHALL always pass through at least one IDLE cycle between any two grants (bus turnaround).
REQ-023 SHALL, on txn_split_ack in GRANTx with split_pending low, set split_pending and load split_owner = x on the same edge the grant drops.
REQ-024 SHALL give txn_split_ack precedence when txn_ack and txn_split_ack arrive in the same cycle.
REQ-025 SHALL, on txn_split_ack while split_pending already high, set protocol_err, end the transaction as if txn_ack, and leave split_owner unchanged.
REQ-026 SHALL, on txn_ack in SPLIT_GRANT, clear split_pending and return to IDLE.
REQ-027 SHALL, if split_req drops in SPLIT_GRANT before txn_ack, return to IDLE with split_pending still set.
REQ-028 SHALL set protocol_err when split_req is high in IDLE with split_pending low, and ignore that request.
REQ-029 SHALL ignore txn_ack/txn_split_ack in IDLE and set protocol_err.
REQ-030 SHALL run a watchdog counter, cleared on grant entry and incremented each grant cycle; on reaching TIMEOUT-1 without completion, release to IDLE and set protocol_err; timeout in SPLIT_GRANT also clears split_pending.
REQ-031 SHALL update last_grant only on entry to GRANT1/GRANT2, not SPLIT_GRANT.

Reset
REQ-032 SHALL, while rst is high, force state IDLE, all grants 0, busy 0, split_pending 0, split_owner 0, protocol_err 0, watchdog 0, last_grant = init2.
REQ-033 SHALL abandon any in-flight grant or pending split immediately on rst assertion, mid-transaction included, with outputs low asynchronously.

Verification
REQ-034 SHALL cover: init1_req high at cycle 0 -> init1_grant at cycle 1; txn_ack at cycle 4 -> grant low at cycle 5, busy low.
REQ-035 SHALL cover: both requests held -> grants alternate init1, init2, init1, each separated by one IDLE cycle.
REQ-036 SHALL cover: init1 granted, txn_split_ack -> split_pending=1, split_owner=0; init2 then granted while init1_req stays high and is not granted; split_req -> split_grant; txn_ack -> split_pending=0.
REQ-037 SHALL cover: TIMEOUT=4, grant with no ack -> grant drops after 4 grant cycles, protocol_err=1.
REQ-038 SHALL cover: simultaneous txn_ack and txn_split_ack -> split_pending=1; a second split_ack while pending -> protocol_err=1, split_owner unchanged.
REQ-039 SHALL cover: rst asserted during SPLIT_GRANT -> split_grant, split_pending, protocol_err all 0 immediately; init1 wins the first tie after release.
